// File: rtl/mod_counter_input.sv
// Modulus counter with a run-time terminal count: Q runs 0..FINAL_VALUE and wraps.
// done flags the terminal count combinationally while counting is enabled.
module mod_counter_input #(
  parameter int unsigned BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [BITS-1:0] FINAL_VALUE,
  output logic [BITS-1:0] Q,
  output logic            done
);

  localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

  // Unsigned >= so a lowered FINAL_VALUE below Q wraps at once instead of overflowing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Q <= '0;
    end else if (enable) begin
      if (Q >= FINAL_VALUE) Q <= '0;
      else                  Q <= Q + ONE;
    end
  end

  always_comb begin
    done = enable && (Q == FINAL_VALUE);
  end

endmodule

// File: tb/tb_mod_counter_input.sv
// Directed bench for mod_counter_input (BITS=4) with hand-computed count sequences.
module tb_mod_counter_input;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic [3:0] FINAL_VALUE;
  logic [3:0] Q;
  logic       done;

  int unsigned checks;
  int unsigned errors;

  mod_counter_input #(.BITS(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .FINAL_VALUE (FINAL_VALUE),
    .Q           (Q),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge, then check Q and the expected done flag.
  task automatic step(input string tag, input int unsigned exp_q, input int unsigned exp_done);
    @(posedge clk);
    #1;
    check_eq({tag, "_q"}, Q, exp_q);
    check_eq({tag, "_done"}, done, exp_done);
  endtask

  initial begin
    int unsigned seq1 [8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
    int unsigned seq2 [10] = '{3, 4, 5, 6, 7, 0, 1, 2, 3, 4};
    checks = 0;
    errors = 0;

    reset_n = 1'b0;
    enable = 1'b1;
    FINAL_VALUE = 4'd5;
    step("reset", 0, 0);
    reset_n = 1'b1;

    foreach (seq1[i]) step("fv5", seq1[i], (seq1[i] == 5) ? 1 : 0);

    FINAL_VALUE = 4'd7;
    foreach (seq2[i]) step("fv7", seq2[i], (seq2[i] == 7) ? 1 : 0);

    enable = 1'b0;
    for (int i = 0; i < 3; i++) step("hold", 4, 0);
    enable = 1'b1;
    step("reenable", 5, 0);

    FINAL_VALUE = 4'd11;
    for (int unsigned v = 6; v <= 9; v++) step("fv11", v, 0);
    FINAL_VALUE = 4'd5;
    step("lowered_fv", 0, 0);

    FINAL_VALUE = 4'd11;
    for (int unsigned v = 1; v <= 6; v++) step("pre_reset", v, 0);
    reset_n = 1'b0;
    step("midreset", 0, 0);
    reset_n = 1'b1;
    step("post_reset", 1, 0);

    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    step("glitch_reset", 2, 0);

    FINAL_VALUE = 4'd15;
    for (int unsigned v = 3; v <= 15; v++) step("full", v, (v == 15) ? 1 : 0);
    step("full_wrap", 0, 0);

    FINAL_VALUE = 4'd0;
    #1 check_eq("fv0_comb_done", done, 1);
    for (int i = 0; i < 3; i++) step("fv0", 0, 1);
    enable = 1'b0;
    #1 check_eq("fv0_disabled_done", done, 0);

    reset_n = 1'b0;
    enable = 1'b1;
    FINAL_VALUE = 4'd9;
    step("reset_prio", 0, 0);
    FINAL_VALUE = 4'd0;
    #1 check_eq("reset_done_fv0", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter_input.md
MOD_COUNTER_INPUT -- requirements
Module: mod_counter_input

Interface
REQ-001 Parameter BITS, default 4, is the counter width in bits; legal range is 2 to 32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port reset_n, input, 1 bit: reset is synchronous and active-low.
REQ-004 Port enable, input, 1 bit: count enable, active-high.
REQ-005 Port FINAL_VALUE, input, BITS bits: run-time terminal count; sampled every cycle, no internal latch.
REQ-006 Port Q, output, BITS bits: registered count value.
REQ-007 Port done, output, 1 bit: combinational terminal-count flag.

Function
REQ-008 The block SHALL be a modulus counter whose count sequence is 0, 1, ..., FINAL_VALUE, 0, ..., a modulus of FINAL_VALUE+1.
REQ-009 On a rising clk edge with reset_n=1 and enable=1, Q SHALL become 0 if Q >= FINAL_VALUE, else Q+1.
REQ-010 On a rising clk edge with reset_n=1 and enable=0, Q SHALL hold its value.
REQ-011 The wrap comparison SHALL be unsigned ">=" so that, if FINAL_VALUE is lowered below the current Q mid-count, the next enabled edge returns Q to 0 without running through the upper range.
REQ-012 If FINAL_VALUE is raised mid-count, counting SHALL continue from the current Q up to the new FINAL_VALUE with no restart.
REQ-013 With FINAL_VALUE=0, Q SHALL stay at 0 on every enabled edge.
REQ-014 With FINAL_VALUE = 2^BITS-1, Q SHALL traverse the full range and wrap from all-ones to 0.
REQ-015 Latency: a change on enable or FINAL_VALUE SHALL take effect at the first rising edge where it is sampled, with no pipeline delay.
REQ-016 done SHALL be 1 exactly when enable=1 and Q == FINAL_VALUE, and SHALL be 0 otherwise.
REQ-017 done SHALL be purely combinational from Q, enable and FINAL_VALUE, with no extra register stage.
REQ-018 Q arithmetic SHALL be BITS wide; no carry out is produced and no value outside 0..2^BITS-1 is ever stored.

Reset
REQ-019 On a rising clk edge with reset_n=0, Q SHALL become 0, regardless of enable or FINAL_VALUE.
REQ-020 Reset SHALL take priority over counting on the same edge.
REQ-021 Asserting reset_n=0 mid-count SHALL return Q to 0 at the next edge, and counting SHALL resume from 0 on the first enabled edge after release.
REQ-022 Deasserting reset_n between edges SHALL have no effect until the next rising edge.
REQ-023 done SHALL read 0 after reset unless enable=1 and FINAL_VALUE=0.

Verification
REQ-024 Scenario: BITS=4, reset for 1 edge, enable=1, FINAL_VALUE=5, run 8 edges -> Q = 1,2,3,4,5,0,1,2; done=1 only while Q=5.
REQ-025 Scenario: from Q=2 set FINAL_VALUE=7, run 10 edges -> Q reaches 7, wraps to 0, then continues counting.
REQ-026 Scenario: at Q=9 with FINAL_VALUE=11, set FINAL_VALUE=5 -> the next edge gives Q=0.
REQ-027 Scenario: enable=0 for 3 edges at Q=4 -> Q holds 4 and done=0; re-enabling gives Q=5 next.
REQ-028 Scenario: reset_n=0 at Q=6 with enable=1 -> the next edge gives Q=0, and the edge after release gives Q=1.
REQ-029 Scenario: FINAL_VALUE=15 -> Q runs 0..15, wraps to 0, and done=1 at Q=15; FINAL_VALUE=0 -> Q stays 0 and done stays 1.
